// File: rtl/route_mutator.sv
// Swap-mutation stage for GA routes: walks each gene position once, and on an
// LFSR hit swaps that gene with an LFSR-chosen partner, then holds the result.
module route_mutator #(
   parameter int NUM_CITIES = 8,
   parameter int CITY_W     = 3,
   parameter int MUT_RATE   = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         seed_load,
   input  logic [15:0]                  seed,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NUM_CITIES*CITY_W-1:0] in_route,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NUM_CITIES*CITY_W-1:0] out_route,
   output logic [CITY_W:0]              mut_count
);

   localparam logic [16:0] THRESH    = 17'((MUT_RATE * 65536) / 10000);
   localparam logic [15:0] LFSR_INIT = 16'hACE1;
   localparam logic [15:0] LFSR_MASK = 16'hB400;
   localparam logic [CITY_W-1:0] LAST_POS = CITY_W'(NUM_CITIES - 1);

   if (CITY_W != $clog2(NUM_CITIES)) begin : g_bad_width
      $error("route_mutator: CITY_W must equal log2(NUM_CITIES)");
   end
   if (NUM_CITIES < 4 || NUM_CITIES > 16 || (NUM_CITIES & (NUM_CITIES - 1)) != 0) begin : g_bad_cities
      $error("route_mutator: NUM_CITIES must be a power of two in 4..16");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [NUM_CITIES-1:0][CITY_W-1:0] route_q;
   logic [NUM_CITIES-1:0][CITY_W-1:0] route_swapped;
   logic [CITY_W-1:0]                 idx_q;
   logic [CITY_W:0]                   cnt_q;
   logic [15:0]                       lfsr_q;
   logic                              mutate;
   logic                              last_pos;
   logic [CITY_W-1:0]                 partner;

   function automatic logic [15:0] lfsr_step(input logic [15:0] r);
      logic [15:0] shifted;
      shifted = r >> 1;
      return r[0] ? (shifted ^ LFSR_MASK) : shifted;
   endfunction

   // An all-zero Galois LFSR would lock up, so zero seeds fall back to the reset value.
   function automatic logic [15:0] seed_value(input logic [15:0] s);
      return (s == 16'h0000) ? LFSR_INIT : s;
   endfunction

   always_comb begin
      mutate   = ({1'b0, lfsr_q} < THRESH);
      partner  = lfsr_q[CITY_W-1:0];
      last_pos = (idx_q == LAST_POS);
      route_swapped          = route_q;
      route_swapped[idx_q]   = route_q[partner];
      route_swapped[partner] = route_q[idx_q];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (last_pos) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         route_q <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         lfsr_q  <= LFSR_INIT;
      end else begin
         if (seed_load) begin
            lfsr_q <= seed_value(seed);
         end else if (state_q == SCAN) begin
            lfsr_q <= lfsr_step(lfsr_q);
         end

         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  route_q <= in_route;
                  idx_q   <= '0;
                  cnt_q   <= '0;
               end
            end
            SCAN: begin
               // idx_q wraps back to 0 after the last position; it is reloaded on accept anyway.
               idx_q <= idx_q + 1'b1;
               if (mutate) begin
                  route_q <= route_swapped;
                  cnt_q   <= cnt_q + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign out_route = route_q;
   assign mut_count = cnt_q;

endmodule

// File: tb/tb_route_mutator.sv
// Bench for route_mutator: three instances (default rate, rate 0, rate 10000)
// driven with random permutations and checked against a behavioural model.
module tb_route_mutator;

   localparam int N  = 8;
   localparam int W  = 3;
   localparam int RW = N * W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst;
   logic [2:0]           seed_load;
   logic [15:0]          seed;
   logic [2:0]           in_valid, in_ready, out_valid, out_ready;
   logic [2:0][RW-1:0]   in_route, out_route;
   logic [2:0][W:0]      mut_count;

   int n_cmp = 0;
   int n_err = 0;
   int unsigned lf [3];
   int unsigned th [3];

   route_mutator #(.NUM_CITIES(8), .CITY_W(3), .MUT_RATE(4)) dut_d (
      .clk(clk), .rst(rst), .seed_load(seed_load[0]), .seed(seed),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_route(in_route[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_route(out_route[0]),
      .mut_count(mut_count[0]));

   route_mutator #(.NUM_CITIES(8), .CITY_W(3), .MUT_RATE(0)) dut_z (
      .clk(clk), .rst(rst), .seed_load(seed_load[1]), .seed(seed),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_route(in_route[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_route(out_route[1]),
      .mut_count(mut_count[1]));

   route_mutator #(.NUM_CITIES(8), .CITY_W(3), .MUT_RATE(10000)) dut_f (
      .clk(clk), .rst(rst), .seed_load(seed_load[2]), .seed(seed),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_route(in_route[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_route(out_route[2]),
      .mut_count(mut_count[2]));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] get_lfsr(input int k);
      case (k)
         0:       return dut_d.lfsr_q;
         1:       return dut_z.lfsr_q;
         default: return dut_f.lfsr_q;
      endcase
   endfunction

   function automatic int unsigned lfsr_next(input int unsigned s);
      int unsigned r;
      r = s >> 1;
      if ((s & 1) != 0) r = r ^ 32'hB400;
      return r & 32'hFFFF;
   endfunction

   // Walk positions 0..N-1; draw r, maybe swap with gene r mod N, then advance.
   task automatic model(input int unsigned thr, input logic [RW-1:0] rin, inout int unsigned s,
                        output logic [RW-1:0] rout, output int cnt);
      int g [N];
      int t, j;
      for (int i = 0; i < N; i++) g[i] = int'(rin[i*W +: W]);
      cnt = 0;
      for (int i = 0; i < N; i++) begin
         if (s < thr) begin
            j = int'(s % N);
            t = g[i]; g[i] = g[j]; g[j] = t;
            cnt++;
         end
         s = lfsr_next(s);
      end
      rout = '0;
      for (int i = 0; i < N; i++) rout[i*W +: W] = g[i][W-1:0];
   endtask

   function automatic logic is_perm(input logic [RW-1:0] r);
      logic [N-1:0] seen;
      seen = '0;
      for (int i = 0; i < N; i++) seen[r[i*W +: W]] = 1'b1;
      return &seen;
   endfunction

   function automatic logic [RW-1:0] rand_route();
      int g [N];
      int t, j;
      logic [RW-1:0] r;
      for (int i = 0; i < N; i++) g[i] = i;
      for (int i = N - 1; i > 0; i--) begin
         j = int'($urandom_range(i, 0));
         t = g[i]; g[i] = g[j]; g[j] = t;
      end
      r = '0;
      for (int i = 0; i < N; i++) r[i*W +: W] = g[i][W-1:0];
      return r;
   endfunction

   function automatic logic [RW-1:0] ident_route();
      logic [RW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[i*W +: W] = W'(i);
      return r;
   endfunction

   task automatic do_seed(input int k, input logic [15:0] s);
      seed         = s;
      seed_load[k] = 1'b1;
      @(negedge clk);
      seed_load[k] = 1'b0;
      lf[k] = (s == 16'h0) ? 32'hACE1 : {16'h0, s};
   endtask

   task automatic run_route(input int k, input logic [RW-1:0] r, input int hold, input bit junk);
      logic [RW-1:0] exp_r;
      int            exp_c;
      int            lat;
      model(th[k], r, lf[k], exp_r, exp_c);
      check("in_ready_idle", in_ready[k], 1);
      in_valid[k] = 1'b1;
      in_route[k] = r;
      @(negedge clk);
      if (junk) in_route[k] = ~r;
      else      in_valid[k] = 1'b0;
      check("in_ready_scan", in_ready[k], 0);
      lat = 0;
      while (!out_valid[k] && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 8);
      for (int h = 0; h < hold; h++) begin
         check("hold_valid", out_valid[k], 1);
         check("hold_route", out_route[k], exp_r);
         check("hold_count", mut_count[k], exp_c);
         check("hold_in_ready", in_ready[k], 0);
         check("hold_lfsr", get_lfsr(k), lf[k]);
         @(negedge clk);
      end
      check("out_route", out_route[k], exp_r);
      check("mut_count", mut_count[k], exp_c);
      check("perm", is_perm(out_route[k]), 1);
      check("lfsr_after", get_lfsr(k), lf[k]);
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
      check("in_ready_release", in_ready[k], 0);
      @(negedge clk);
      out_ready[k] = 1'b0;
      check("out_valid_idle", out_valid[k], 0);
   endtask

   initial begin
      logic [RW-1:0] r;
      th[0] = (4 * 65536) / 10000;
      th[1] = (0 * 65536) / 10000;
      th[2] = (10000 * 65536) / 10000;
      rst = 1'b1; seed_load = '0; seed = '0;
      in_valid = '0; out_ready = '0; in_route = '0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check("rst_in_ready", in_ready[k], 1);
         check("rst_out_valid", out_valid[k], 0);
         check("rst_out_route", out_route[k], 0);
         check("rst_mut_count", mut_count[k], 0);
         check("rst_lfsr", get_lfsr(k), 16'hACE1);
         lf[k] = 32'hACE1;
      end
      rst = 1'b0;
      @(negedge clk);

      // rate 0: route passes through untouched
      run_route(1, ident_route(), 1, 0);
      check("zero_rate_ident", out_route[1], ident_route());
      for (int n = 0; n < 5; n++) run_route(1, rand_route(), $urandom_range(2, 0), 1'($urandom_range(1, 0)));

      // rate 10000: every position swaps, starting from the reset LFSR value
      run_route(2, ident_route(), 1, 0);
      check("full_rate_count", mut_count[2], 8);
      for (int n = 0; n < 40; n++) begin
         if (n % 8 == 0) do_seed(2, 16'($urandom));
         run_route(2, rand_route(), $urandom_range(2, 0), 1'($urandom_range(1, 0)));
      end

      // default rate: nonzero seed, then seed 0 falls back to ACE1
      do_seed(0, 16'h1234);
      check("seed_load", get_lfsr(0), 16'h1234);
      for (int n = 0; n < 5; n++) run_route(0, rand_route(), 0, 0);
      do_seed(0, 16'h0000);
      check("seed_zero", get_lfsr(0), 16'hACE1);
      for (int n = 0; n < 1000; n++)
         run_route(0, rand_route(), $urandom_range(1, 0), ($urandom_range(3, 0) == 0));

      // long back-pressure in HOLD
      run_route(0, rand_route(), 20, 0);

      // reset mid-scan, with a competing seed_load in the same cycle
      r = rand_route();
      in_valid[2] = 1'b1;
      in_route[2] = r;
      @(negedge clk);
      in_valid[2] = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      seed = 16'h0005;
      seed_load[0] = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seed_load[0] = 1'b0;
      check("midrst_in_ready", in_ready[2], 1);
      check("midrst_out_valid", out_valid[2], 0);
      check("midrst_route", out_route[2], 0);
      check("midrst_count", mut_count[2], 0);
      check("midrst_lfsr", get_lfsr(2), 16'hACE1);
      check("midrst_seed_lfsr", get_lfsr(0), 16'hACE1);
      for (int k = 0; k < 3; k++) lf[k] = 32'hACE1;
      run_route(2, r, 1, 0);
      run_route(0, rand_route(), 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/route_mutator.md
ROUTE_MUTATOR -- requirements
Module: route_mutator

Interface
REQ-001 The block SHALL have parameter NUM_CITIES, default 8: cities per route, power of two, 4..16.
REQ-002 The block SHALL have parameter CITY_W, default 3: bits per city index, equal to log2(NUM_CITIES).
REQ-003 The block SHALL have parameter MUT_RATE, default 4: per-gene mutation probability in units of 1/10000.
REQ-004 The block SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-005 The block SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 The block SHALL have port seed_load, input, 1: load LFSR from seed this cycle.
REQ-007 The block SHALL have port seed, input, 16: LFSR seed value.
REQ-008 The block SHALL have port in_valid, input, 1: child route from BREED stage valid.
REQ-009 The block SHALL have port in_ready, output, 1: block can accept a route.
REQ-010 The block SHALL have port in_route, input, NUM_CITIES*CITY_W: child route, gene i at bits [i*CITY_W +: CITY_W].
REQ-011 The block SHALL have port out_valid, output, 1: mutated route valid for NEXT_GEN stage.
REQ-012 The block SHALL have port out_ready, input, 1: downstream accepts route.
REQ-013 The block SHALL have port out_route, output, NUM_CITIES*CITY_W: mutated route, same packing as in_route.
REQ-014 The block SHALL have port mut_count, output, CITY_W+1: number of swaps performed on out_route.

Function
REQ-015 The block SHALL implement states IDLE, SCAN, HOLD.
REQ-016 In IDLE, in_ready SHALL be 1; on in_valid&in_ready the block SHALL register in_route, clear position index i to 0, clear mut_count, go to SCAN.
REQ-017 In SCAN, in_ready and out_valid SHALL be 0; one gene position SHALL be processed per cycle, i = 0..NUM_CITIES-1.
REQ-018 Threshold SHALL be the 17-bit elaboration constant THRESH = (MUT_RATE*65536)/10000, integer truncation (26 at default).
REQ-019 At position i, with current LFSR value r, the block SHALL mutate iff {1'b0,r} < THRESH.
REQ-020 On mutate, partner j SHALL be r[CITY_W-1:0]; genes i and j SHALL be swapped in one cycle; j==i SHALL leave the route unchanged but still count as a swap.
REQ-021 On mutate, mut_count SHALL increment by 1; it cannot overflow (max NUM_CITIES).
REQ-022 The LFSR SHALL advance exactly once per SCAN cycle and SHALL NOT advance in IDLE or HOLD.
REQ-023 LFSR SHALL be 16-bit Galois, right shift, mask 16'hB400 applied when shifted-out bit is 1.
REQ-024 After processing i = NUM_CITIES-1 the block SHALL enter HOLD; SCAN latency SHALL be exactly NUM_CITIES cycles.
REQ-025 In HOLD, out_valid SHALL be 1 and out_route/mut_count SHALL be stable until out_valid&out_ready.
REQ-026 On out_valid&out_ready, the block SHALL return to IDLE; in_ready SHALL be 0 in that same cycle (no same-cycle accept).
REQ-027 seed_load SHALL load the LFSR in any state, taking priority over LFSR advance; seed 16'h0000 SHALL load 16'hACE1.
REQ-028 out_route SHALL always be a permutation of the accepted in_route; swap-only mutation guarantees this.
REQ-029 in_valid outside IDLE SHALL be ignored; upstream holds it per valid/ready protocol.

Reset
REQ-030 On rst the block SHALL enter IDLE; in_ready=1, out_valid=0, out_route=0, mut_count=0, i=0, LFSR=16'hACE1.
REQ-031 rst SHALL override seed_load and any handshake in the same cycle; a route in SCAN or HOLD SHALL be discarded.

Verification
REQ-032 MUT_RATE=0 (THRESH=0): accept route 0,1,...,7 -> out_valid exactly 8 cycles after accept, out_route unchanged, mut_count=0.
REQ-033 MUT_RATE=10000 (THRESH=65536): every position mutates -> mut_count=8, out_route matches reference model run from seed 16'hACE1, is a permutation.
REQ-034 Default params, seed_load seed=0 -> LFSR=16'hACE1; 1000 routes back-to-back -> every output a permutation, results bit-exact vs model.
REQ-035 out_ready held 0 for 20 cycles in HOLD -> out_route, mut_count, out_valid stable, in_ready=0, LFSR unchanged.
REQ-036 rst asserted at SCAN position 4 -> next cycle IDLE, in_ready=1, out_valid=0, LFSR=16'hACE1; next route processed from clean state.
